// File: rtl/c_fetch_aligner.sv
// rtl/c_fetch_aligner.sv - realigns word fetches into a 16/32-bit instruction stream with RV32C expansion
module c_fetch_aligner #(
  parameter int ADDR_W   = 8,
  parameter int RESET_PC = 0,
  parameter int C_EXT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  output logic              fetch_req,
  output logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_valid,
  input  logic [31:0]       fetch_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_compressed,
  output logic              out_illegal
);

  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);

  // Returns {illegal, instr}; unsupported encodings give {1, 0}.
  function automatic logic [32:0] expand(input logic [15:0] c);
    logic [4:0]  rd_p, rs_p, rd, rs2;
    logic [11:0] imm_i;
    logic [20:0] joff;
    logic [32:0] r;
    rd_p  = {2'b01, c[4:2]};
    rs_p  = {2'b01, c[9:7]};
    rd    = c[11:7];
    rs2   = c[6:2];
    imm_i = {{6{c[12]}}, c[12], c[6:2]};
    joff  = {{10{c[12]}}, c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0};
    r     = {1'b1, 32'h0};
    case ({c[1:0], c[15:13]})
      5'b00_010: r = {1'b0, 5'b0, c[5], c[12:10], c[6], 2'b00, rs_p, 3'b010, rd_p, 7'b0000011};
      5'b00_110: r = {1'b0, 5'b0, c[5], c[12], rd_p, rs_p, 3'b010, c[11:10], c[6], 2'b00, 7'b0100011};
      5'b01_000: r = {1'b0, imm_i, rd, 3'b000, rd, 7'b0010011};
      5'b01_010: r = {1'b0, imm_i, 5'd0, 3'b000, rd, 7'b0010011};
      5'b01_101: r = {1'b0, joff[20], joff[10:1], joff[11], joff[19:12], 5'd0, 7'b1101111};
      5'b10_100: begin
        if (!c[12]) begin
          if (rs2 == 5'd0) begin
            if (rd != 5'd0) r = {1'b0, 12'd0, rd, 3'b000, 5'd0, 7'b1100111};
          end else begin
            r = {1'b0, 7'd0, rs2, 5'd0, 3'b000, rd, 7'b0110011};
          end
        end else if (rs2 != 5'd0) begin
          r = {1'b0, 7'd0, rs2, rd, 3'b000, rd, 7'b0110011};
        end
      end
      default: r = {1'b1, 32'h0};
    endcase
    if (C_EXT == 0) r = {1'b1, 32'h0};
    return r;
  endfunction

  logic [15:0]       hw_q [3];
  logic [15:0]       hw_d [3];
  logic [1:0]        cnt_q, cnt_d;
  logic              outstanding_q, outstanding_d;
  logic              discard_q, discard_d;
  logic              skip_lo_q, skip_lo_d;
  logic              run_q, run_d;
  logic [ADDR_W-1:0] fetch_ptr_q, fetch_ptr_d;
  logic [ADDR_W-1:0] out_pc_q, out_pc_d;

  logic        is32, take;
  logic [1:0]  used, rem;
  logic [32:0] exp_w;

  assign fetch_req  = run_q & (cnt_q < 2'd2) & ~outstanding_q & ~flush;
  assign fetch_addr = fetch_ptr_q;
  assign out_pc     = out_pc_q;

  always_comb begin
    is32           = (hw_q[0][1:0] == 2'b11);
    out_valid      = ((cnt_q != 2'd0) && !is32) || (cnt_q >= 2'd2);
    exp_w          = expand(hw_q[0]);
    out_instr      = 32'h0;
    out_compressed = 1'b0;
    out_illegal    = 1'b0;
    if (out_valid) begin
      if (is32) begin
        out_instr = {hw_q[1], hw_q[0]};
      end else begin
        out_compressed = 1'b1;
        out_illegal    = exp_w[32];
        out_instr      = exp_w[31:0];
      end
    end
  end

  always_comb begin
    hw_d          = hw_q;
    skip_lo_d     = skip_lo_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    fetch_ptr_d   = fetch_ptr_q;
    out_pc_d      = out_pc_q;
    run_d         = 1'b1;
    take          = out_valid & out_ready;
    used          = take ? (is32 ? 2'd2 : 2'd1) : 2'd0;

    if (take) begin
      out_pc_d = out_pc_q + (is32 ? ADDR_W'(4) : ADDR_W'(2));
      if (is32) begin
        hw_d[0] = hw_q[2];
      end else begin
        hw_d[0] = hw_q[1];
        hw_d[1] = hw_q[2];
      end
    end
    rem   = cnt_q - used;
    cnt_d = rem;

    // Appended halfwords land after whatever survives this cycle's consume.
    if (fetch_valid) begin
      outstanding_d = 1'b0;
      if (discard_q) begin
        discard_d = 1'b0;
      end else if (skip_lo_q) begin
        skip_lo_d = 1'b0;
        cnt_d     = rem + 2'd1;
        case (rem)
          2'd0:    hw_d[0] = fetch_data[31:16];
          2'd1:    hw_d[1] = fetch_data[31:16];
          default: hw_d[2] = fetch_data[31:16];
        endcase
      end else begin
        cnt_d = rem + 2'd2;
        if (rem == 2'd0) {hw_d[1], hw_d[0]} = fetch_data;
        else             {hw_d[2], hw_d[1]} = fetch_data;
      end
    end

    if (fetch_req) begin
      outstanding_d = 1'b1;
      fetch_ptr_d   = fetch_ptr_q + ADDR_W'(4);
    end

    if (flush) begin
      cnt_d         = 2'd0;
      fetch_ptr_d   = {flush_pc[ADDR_W-1:2], 2'b00};
      skip_lo_d     = flush_pc[1];
      out_pc_d      = flush_pc;
      outstanding_d = outstanding_q & ~fetch_valid;
      discard_d     = outstanding_q & ~fetch_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) hw_q[i] <= 16'h0;
      cnt_q         <= 2'd0;
      outstanding_q <= 1'b0;
      discard_q     <= 1'b0;
      skip_lo_q     <= RST_PC[1];
      run_q         <= 1'b0;
      fetch_ptr_q   <= {RST_PC[ADDR_W-1:2], 2'b00};
      out_pc_q      <= RST_PC;
    end else begin
      hw_q          <= hw_d;
      cnt_q         <= cnt_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      skip_lo_q     <= skip_lo_d;
      run_q         <= run_d;
      fetch_ptr_q   <= fetch_ptr_d;
      out_pc_q      <= out_pc_d;
    end
  end

endmodule

// File: tb/tb_c_fetch_aligner.sv
// tb/tb_c_fetch_aligner.sv - directed bench for c_fetch_aligner with a latency-varying memory responder
module tb_c_fetch_aligner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [7:0]  flush_pc = 8'h0;
  logic        fetch_req;
  logic [7:0]  fetch_addr;
  logic        fetch_valid = 1'b0;
  logic [31:0] fetch_data = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [7:0]  out_pc;
  logic        out_compressed;
  logic        out_illegal;

  logic        fr0, ov0, oc0, oi0;
  logic [7:0]  fa0, op0;
  logic [31:0] ins0;

  c_fetch_aligner #(.ADDR_W(8), .RESET_PC(0), .C_EXT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .flush_pc(flush_pc),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_compressed(out_compressed), .out_illegal(out_illegal)
  );

  c_fetch_aligner #(.ADDR_W(8), .RESET_PC(0), .C_EXT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .flush_pc(flush_pc),
    .fetch_req(fr0), .fetch_addr(fa0),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .out_valid(ov0), .out_ready(out_ready), .out_instr(ins0),
    .out_pc(op0), .out_compressed(oc0), .out_illegal(oi0)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [64];
  int          n_tests = 0;
  int          n_fail = 0;

  // Memory responder: one request in flight, response 1..4 cycles later.
  logic        lat_rand = 1'b0;
  int          resp_lat = 0;
  logic        pend = 1'b0;
  int          cd = 0;
  logic [7:0]  paddr = 8'h0;
  int          req_count = 0;
  logic [7:0]  last_req_addr = 8'h0;
  logic        took;
  logic [7:0]  took_a;

  always @(posedge clk) begin
    took   = fetch_req;
    took_a = fetch_addr;
    #1;
    fetch_valid = 1'b0;
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (took) begin
        pend = 1'b1;
        cd = lat_rand ? int'($urandom_range(0, 3)) : resp_lat;
        paddr = took_a;
        req_count++;
        last_req_addr = took_a;
      end
      if (pend) begin
        if (cd == 0) begin
          fetch_valid = 1'b1;
          fetch_data  = mem[paddr[7:2]];
          pend = 1'b0;
        end else begin
          cd--;
        end
      end
    end
  end

  typedef struct packed {
    logic [7:0]  pc;
    logic [31:0] instr;
    logic        comp;
    logic        ill;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic load_prog();
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0] = 32'h00930405; mem[1] = 32'h04050050; mem[2] = 32'h0000557D;
    mem[3] = 32'hC5044144; mem[4] = 32'hBFFDA021; mem[5] = 32'h929A829A;
    mem[6] = 32'h14018082; mem[7] = 32'h05130001; mem[8] = 32'h9082ABC0;
    mem[9] = 32'h04050405;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("rst_fetch_req", 32'(fetch_req), 32'h0);
    chk("rst_fetch_addr", 32'(fetch_addr), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_pc", 32'(out_pc), 32'h0);
    chk("rst_out_flags", {30'h0, out_compressed, out_illegal}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called at a negedge; holds out_ready high until one instruction is taken.
  task automatic expect_out(input string nm, input logic [7:0] pc, input logic [31:0] ins);
    int k;
    k = 0;
    out_ready = 1'b1;
    while (!out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!out_valid) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: got no out_valid expected out_valid within 50 cycles", nm);
    end else begin
      chk({nm, "_pc"}, 32'(out_pc), 32'(pc));
      chk({nm, "_instr"}, out_instr, ins);
    end
    @(negedge clk);
  endtask

  initial begin
    int          idx, cyc, k, rc0;
    logic        hold, fr_mis;
    logic [7:0]  h_pc;
    logic [31:0] h_ins;
    logic [31:0] e_ins0;

    tbl[0]  = '{8'h00, 32'h00140413, 1'b1, 1'b0};
    tbl[1]  = '{8'h02, 32'h00500093, 1'b0, 1'b0};
    tbl[2]  = '{8'h06, 32'h00140413, 1'b1, 1'b0};
    tbl[3]  = '{8'h08, 32'hFFF00513, 1'b1, 1'b0};
    tbl[4]  = '{8'h0A, 32'h00000000, 1'b1, 1'b1};
    tbl[5]  = '{8'h0C, 32'h00452483, 1'b1, 1'b0};
    tbl[6]  = '{8'h0E, 32'h00952423, 1'b1, 1'b0};
    tbl[7]  = '{8'h10, 32'h0080006F, 1'b1, 1'b0};
    tbl[8]  = '{8'h12, 32'hFFFFF06F, 1'b1, 1'b0};
    tbl[9]  = '{8'h14, 32'h006002B3, 1'b1, 1'b0};
    tbl[10] = '{8'h16, 32'h006282B3, 1'b1, 1'b0};
    tbl[11] = '{8'h18, 32'h00008067, 1'b1, 1'b0};
    tbl[12] = '{8'h1A, 32'hFE040413, 1'b1, 1'b0};
    tbl[13] = '{8'h1C, 32'h00000013, 1'b1, 1'b0};
    tbl[14] = '{8'h1E, 32'hABC00513, 1'b0, 1'b0};
    tbl[15] = '{8'h22, 32'h00000000, 1'b1, 1'b1};
    tbl[16] = '{8'h24, 32'h00140413, 1'b1, 1'b0};
    tbl[17] = '{8'h26, 32'h00140413, 1'b1, 1'b0};

    // Program stream with random latency and random decode back-pressure.
    load_prog();
    lat_rand = 1'b1;
    do_reset();
    idx = 0; cyc = 0; hold = 1'b0; fr_mis = 1'b0; h_pc = 8'h0; h_ins = 32'h0;
    while (idx < 18 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (fr0 !== fetch_req || fa0 !== fetch_addr) fr_mis = 1'b1;
      if (hold) begin
        chk("hold_valid", 32'(out_valid), 32'h1);
        chk("hold_pc", 32'(out_pc), 32'(h_pc));
        chk("hold_instr", out_instr, h_ins);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if (out_valid && out_ready) begin
        e_ins0 = tbl[idx].comp ? 32'h0 : tbl[idx].instr;
        chk($sformatf("v%0d_pc", idx), 32'(out_pc), 32'(tbl[idx].pc));
        chk($sformatf("v%0d_instr", idx), out_instr, tbl[idx].instr);
        chk($sformatf("v%0d_flags", idx), {30'h0, out_compressed, out_illegal},
            {30'h0, tbl[idx].comp, tbl[idx].ill});
        chk($sformatf("v%0d_c0_instr", idx), ins0, e_ins0);
        chk($sformatf("v%0d_c0_flags", idx), {29'h0, ov0, oc0, oi0},
            {29'h0, 1'b1, tbl[idx].comp, tbl[idx].comp});
        idx++;
      end
      hold  = out_valid & ~out_ready;
      h_pc  = out_pc;
      h_ins = out_instr;
    end
    chk("table_done", 32'(idx), 32'd18);
    chk("c0_fetch_same", 32'(fr_mis), 32'h0);

    // Back-pressure with three halfwords buffered.
    load_prog();
    mem[0] = 32'h557D557D; mem[1] = 32'h557D557D;
    lat_rand = 1'b0; resp_lat = 1;
    do_reset();
    expect_out("st0", 8'h00, 32'hFFF00513);
    out_ready = 1'b0;
    repeat (10) @(negedge clk);
    chk("st_refetch_addr", 32'(last_req_addr), 32'h04);
    for (int i = 0; i < 5; i++) begin
      chk("st_valid", 32'(out_valid), 32'h1);
      chk("st_pc", 32'(out_pc), 32'h02);
      chk("st_instr", out_instr, 32'hFFF00513);
      chk("st_no_fetch", 32'(fetch_req), 32'h0);
      @(negedge clk);
    end
    expect_out("st2", 8'h02, 32'hFFF00513);
    expect_out("st4", 8'h04, 32'hFFF00513);
    expect_out("st6", 8'h06, 32'hFFF00513);

    // Flush to a halfword target while the first fetch is outstanding.
    load_prog();
    mem[0] = 32'h557D557D;
    resp_lat = 4;
    do_reset();
    rc0 = req_count; k = 0;
    while (req_count == rc0 && k < 30) begin
      @(negedge clk);
      k++;
    end
    chk("fl_req_seen", 32'(req_count - rc0), 32'd1);
    flush = 1'b1; flush_pc = 8'h06;
    #1;
    chk("fl_req_low", 32'(fetch_req), 32'h0);
    @(negedge clk);
    flush = 1'b0;
    k = 0;
    while (req_count < rc0 + 2 && k < 30) begin
      @(negedge clk);
      k++;
    end
    chk("fl_new_addr", 32'(last_req_addr), 32'h04);
    expect_out("fl6", 8'h06, 32'h00140413);
    expect_out("fl8", 8'h08, 32'hFFF00513);

    // Asynchronous reset in mid-stream, then restart at address 0.
    load_prog();
    resp_lat = 0;
    do_reset();
    expect_out("mr0", 8'h00, 32'h00140413);
    expect_out("mr2", 8'h02, 32'h00500093);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_valid", 32'(out_valid), 32'h0);
    chk("mr_instr", out_instr, 32'h0);
    chk("mr_pc", 32'(out_pc), 32'h0);
    chk("mr_flags", {30'h0, out_compressed, out_illegal}, 32'h0);
    chk("mr_fetch", {23'h0, fetch_req, fetch_addr}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    expect_out("mr_re0", 8'h00, 32'h00140413);
    expect_out("mr_re2", 8'h02, 32'h00500093);
    expect_out("mr_re6", 8'h06, 32'h00140413);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish before 300000");
    $fatal(1, "watchdog");
  end

endmodule
